// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Brief    : Shared encodings, shadow-stage types and compare helpers.
// Revision : 1.0
// ============================================================================
package hazard_ctrl_pkg;

    localparam int CNT_W           = 4;
    localparam int MD_MULT_CYC_DEF = 5;
    localparam int MD_DIV_CYC_DEF  = 10;

    localparam logic [1:0] TUSE_NONE  = 2'd3;

    localparam logic [1:0] D_FWD_GRF  = 2'd0;
    localparam logic [1:0] D_FWD_E    = 2'd1;
    localparam logic [1:0] D_FWD_M    = 2'd2;

    localparam logic [1:0] E_FWD_PIPE = 2'd0;
    localparam logic [1:0] E_FWD_M    = 2'd1;
    localparam logic [1:0] E_FWD_W    = 2'd2;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wa;
        logic [1:0] tnew;
    } e_shadow_t;

    typedef struct packed {
        logic [4:0] rt;
        logic [4:0] wa;
        logic [1:0] tnew;
    } m_shadow_t;

    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] wa);
        return (r != 5'd0) && (r == wa);
    endfunction

    function automatic logic [1:0] tnew_step(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic tuse_conflict(input logic [1:0] tuse,
                                           input logic       hit_e,
                                           input logic [1:0] tnew_e,
                                           input logic       hit_m,
                                           input logic [1:0] tnew_m);
        return (tuse != TUSE_NONE) &&
               ((hit_e && (tnew_e > tuse)) || (hit_m && (tnew_m > tuse)));
    endfunction

    function automatic logic [1:0] fwd_d_sel(input logic       hit_e,
                                             input logic [1:0] tnew_e,
                                             input logic       hit_m,
                                             input logic [1:0] tnew_m);
        if (hit_e && (tnew_e == 2'd0)) begin
            return D_FWD_E;
        end
        if (hit_m && (tnew_m == 2'd0)) begin
            return D_FWD_M;
        end
        return D_FWD_GRF;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic       hit_m,
                                             input logic [1:0] tnew_m,
                                             input logic       hit_w);
        if (hit_m && (tnew_m == 2'd0)) begin
            return E_FWD_M;
        end
        if (hit_w) begin
            return E_FWD_W;
        end
        return E_FWD_PIPE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_md_busy_cnt.sv
`default_nettype none
// ============================================================================
// Module   : md_busy_cnt
// Brief    : Multiply/divide busy counter; busy while the count is nonzero.
// Revision : 1.0
// ============================================================================
module md_busy_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MD_MULT_CYC_DEF,
    parameter int DIV_CYC  = MD_DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic div_i,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A start always reloads, even one arriving while still busy.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = div_i ? DIV_LD : MULT_LD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : E/M/W shadow pipeline driving forwarding selects and the stall.
// Revision : 1.0
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MD_MULT_CYC_DEF,
    parameter int DIV_CYC  = MD_DIV_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic [4:0] wa_D,
    input  logic [1:0] tnew_D,
    input  logic       md_use_D,
    input  logic       md_start_E,
    input  logic       md_div_E,
    output logic       stall,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic       mfrtm_c,
    output logic       md_busy
);

    e_shadow_t  e_q, e_d;
    m_shadow_t  m_q, m_d;
    logic [4:0] w_wa_q, w_wa_d;

    logic rs_hit_e, rs_hit_m, rt_hit_e, rt_hit_m;
    logic rse_hit_m, rse_hit_w, rte_hit_m, rte_hit_w;
    logic stall_rs, stall_rt, stall_md;

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_cnt (
        .clk     (clk),
        .reset   (reset),
        .start_i (md_start_E),
        .div_i   (md_div_E),
        .busy_o  (md_busy)
    );

    always_comb begin
        rs_hit_e  = reg_match(rs_D, e_q.wa);
        rs_hit_m  = reg_match(rs_D, m_q.wa);
        rt_hit_e  = reg_match(rt_D, e_q.wa);
        rt_hit_m  = reg_match(rt_D, m_q.wa);
        rse_hit_m = reg_match(e_q.rs, m_q.wa);
        rse_hit_w = reg_match(e_q.rs, w_wa_q);
        rte_hit_m = reg_match(e_q.rt, m_q.wa);
        rte_hit_w = reg_match(e_q.rt, w_wa_q);

        stall_rs  = tuse_conflict(tuse_rs_D, rs_hit_e, e_q.tnew, rs_hit_m, m_q.tnew);
        stall_rt  = tuse_conflict(tuse_rt_D, rt_hit_e, e_q.tnew, rt_hit_m, m_q.tnew);
        // The E-stage start is counted too: md_busy only rises a cycle later.
        stall_md  = md_use_D && (md_busy || md_start_E);
        stall     = stall_rs || stall_rt || stall_md;

        fwd_rs_D  = fwd_d_sel(rs_hit_e, e_q.tnew, rs_hit_m, m_q.tnew);
        fwd_rt_D  = fwd_d_sel(rt_hit_e, e_q.tnew, rt_hit_m, m_q.tnew);
        fwd_rs_E  = fwd_e_sel(rse_hit_m, m_q.tnew, rse_hit_w);
        fwd_rt_E  = fwd_e_sel(rte_hit_m, m_q.tnew, rte_hit_w);
        mfrtm_c   = reg_match(m_q.rt, w_wa_q);
    end

    always_comb begin
        e_d      = stall ? '0 : '{rs: rs_D, rt: rt_D, wa: wa_D, tnew: tnew_D};
        m_d.rt   = e_q.rt;
        m_d.wa   = e_q.wa;
        m_d.tnew = tnew_step(e_q.tnew);
        w_wa_d   = m_q.wa;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_wa_q <= '0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_wa_q <= w_wa_d;
        end
    end

endmodule
`default_nettype wire
